key_event_fifo: RTL

KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

---
 rtl/key_event_fifo.sv | 122 ++++++++++++
 1 files changed

// File: rtl/key_event_fifo.sv
// ---------------------------------------------------------------------------
// key_event_fifo
//   Small show-ahead FIFO between a keypad scanner and an SPI shifter. Each
//   capture request stores the current {cols,rows} code; the consumer drains
//   the head entry with a valid/ready handshake.
//
// Optional feature macro: KEY_REPEAT_FILTER_EN
//   When defined, a held key (latch_en high on consecutive cycles with the
//   same code) is enqueued only once per latch_en burst.
//
// Parameters
//   ROW_W  row-code width
//   COL_W  column-code width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   latch_en    capture request for the current key code
//   rows, cols  key code inputs
//   data_out    head entry {cols,rows}; all-zero while empty
//   data_valid  FIFO holds at least one entry
//   data_ready  consumer accepts the head entry
//   count       number of stored entries
//   overflow    sticky flag: a key code was dropped because the FIFO was full
//   ovf_clr     single-cycle clear for overflow (a same-cycle drop wins)
//
// Handshake: an entry is popped on a rising edge where data_valid and
// data_ready are both high; data_ready while empty is ignored. There is no
// same-cycle bypass, so a pushed entry appears on data_out one cycle later.
// ---------------------------------------------------------------------------
module key_event_fifo #(
  parameter int ROW_W = 4,
  parameter int COL_W = 2,
  parameter int DEPTH = 4,
  localparam int DW = COL_W + ROW_W,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          latch_en,
  input  logic [ROW_W-1:0] rows,
  input  logic [COL_W-1:0] cols,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  input  logic          data_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [DW-1:0] w_code;
  logic          w_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_code = {cols, rows};
  assign w_pop  = (r_count != '0) && data_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push = w_req && ((r_count != FULL_CNT) || w_pop);
  assign w_drop = w_req && !w_push;

`ifdef KEY_REPEAT_FILTER_EN
  logic          r_last_en;
  logic [DW-1:0] r_last_code;

  // Suppress a request that continues a burst with the code already queued.
  assign w_req = latch_en && !(r_last_en && (w_code == r_last_code));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_en   <= 1'b0;
      r_last_code <= '0;
    end else begin
      r_last_en <= latch_en;
      if (w_push) r_last_code <= w_code;
    end
  end
`else
  assign w_req = latch_en;
`endif

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= w_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign data_valid = (r_count != '0);
  assign data_out   = data_valid ? r_mem[r_rd_ptr] : '0;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule
